usrt_rx: RTL
============

USRT_RX -- requirements
Module: usrt_rx

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame.
REQ-002 The block SHALL have parameter PARITY_EN, default 1, meaning an even-parity bit follows the payload when 1 and is absent when 0.
REQ-003 clk  input  1  system clock; every flop is clocked on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 usrt_clk  input  1  serial bit clock from the transmitter; asynchronous to clk; at most clk/4.
REQ-006 RTS  input  1  request-to-send from the transmitter; high for the whole frame.
REQ-007 RXD  input  1  serial data line; idles high.
REQ-008 CTS  output  1  clear-to-send; high while the block can accept a new frame.
REQ-009 rx_data  output  DATA_BITS  last accepted payload.
REQ-010 rx_valid  output  1  rx_data holds an unacknowledged payload.
REQ-011 rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-012 parity_err, frame_err, overrun  output  1 each  one-clk error pulses.

Function
REQ-013 usrt_clk, RTS and RXD SHALL each pass through a two-flop synchronizer of equal depth.
REQ-014 A one-clk strobe SHALL fire on each synchronized usrt_clk rising edge; all serial sampling SHALL happen only on this strobe.
REQ-015 Frame format SHALL be: start bit 0, then DATA_BITS payload bits LSB first, then a parity bit if PARITY_EN, then stop bit 1.
REQ-016 FSM states SHALL be IDLE, DATA, PARITY and STOP.
REQ-017 IDLE: on a strobe with RTS=1 and RXD=0, the FSM SHALL clear the bit counter and go to DATA; RXD=1 keeps it in IDLE.
REQ-018 DATA: each strobe SHALL shift in one bit; after DATA_BITS bits the FSM SHALL go to PARITY (PARITY_EN=1) or STOP.
REQ-019 PARITY: one strobe SHALL latch the bit; error when the XOR of payload and parity bit is 1; next state STOP.
REQ-020 STOP: one strobe SHALL sample the stop bit, and the FSM SHALL return to IDLE.
REQ-021 Frame accepted (stop=1, parity ok): rx_data SHALL load and rx_valid SHALL rise on the clk after the stop strobe.
REQ-022 Parity error: parity_err SHALL pulse on the clk after the stop strobe; rx_data and rx_valid SHALL be unchanged.
REQ-023 Stop bit 0: frame_err SHALL pulse on the clk after the stop strobe, also suppressing parity_err; rx_data and rx_valid SHALL be unchanged.
REQ-024 Synchronized RTS low in any non-IDLE state SHALL abort to IDLE on the next clk, discarding the partial payload, with no flag.
REQ-025 Accepted frame while rx_valid=1: overrun SHALL pulse; rx_data SHALL keep the old payload; rx_valid SHALL stay 1.
REQ-026 Accepted frame in the same clk as rx_ack=1: the new payload SHALL load, rx_valid SHALL stay 1, and no overrun SHALL occur.
REQ-027 rx_ack with rx_valid=0 SHALL have no effect.
REQ-028 CTS SHALL equal (state==IDLE) AND NOT rx_valid, registered.
REQ-029 Latency from a usrt_clk rising edge to its strobe SHALL be 3 clk cycles.

Reset
REQ-030 While rst=0 at a clk edge: state=IDLE, bit counter=0, shift register=0, synchronizers=1 for RXD and 0 for the others.
REQ-031 While rst=0 at a clk edge: rx_data=0, rx_valid=0, CTS=0 and all error pulses=0.
REQ-032 Reset mid-frame SHALL discard the frame, and no flag SHALL follow after reset release.
REQ-033 CTS SHALL rise on the first clk after reset release.

Structure
REQ-034 Package usrt_pkg SHALL hold the FSM state enum, the default DATA_BITS, and the start/stop bit constants shared with the transmitter.
REQ-035 Sub-module usrt_sync_edge SHALL implement the synchronizer plus rising-edge strobe and SHALL be instantiated once, for usrt_clk.

Verification
REQ-036 Bench: clk 100 MHz, usrt_clk 25 MHz, rst pulsed low 10 ns at start.
REQ-037 Frame 0xA5, parity 0, stop 1 -> rx_data=0xA5 and rx_valid=1 one clk after the stop strobe; no error pulses; CTS=0 until rx_ack.
REQ-038 Frame 0x3C with parity 1 -> parity_err pulses once, rx_valid stays 0, rx_data stays 0x00.
REQ-039 Frame 0xFF with stop 0 -> frame_err pulses once, rx_valid stays 0.
REQ-040 RTS dropped after 4 payload bits, then a full frame 0x12 -> no valid for the partial frame, rx_data=0x12 for the full one.
REQ-041 Frames 0x55 then 0xAA with no rx_ack -> overrun pulses once, rx_data stays 0x55; rx_ack in the stop-strobe clk of 0xAA instead -> rx_data=0xAA and no overrun.
REQ-042 rst=0 during bit 5 of frame 0x81, then a full frame 0x7E -> outputs at reset values, no flags for the aborted frame, then rx_data=0x7E.

Source files
------------

// File: rtl/usrt_pkg.sv
// Shared definitions for the synchronous serial receiver and its transmitter peer.
package usrt_pkg;

    localparam int   USRT_DATA_BITS = 8;
    localparam logic USRT_START_BIT = 1'b0;
    localparam logic USRT_STOP_BIT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } usrt_state_e;

endpackage

// File: rtl/usrt_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a one-clk strobe on its rising edge.
module usrt_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // NOTE: reset is synchronous here, so rst appears inside the clocked branch only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], d_i};
            prev_q <= sync_q[1];
        end
    end

    assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/usrt_rx.sv
// Synchronous serial receiver: samples RXD on each usrt_clk rising edge and
// delivers framed payloads with parity/framing/overrun reporting.
module usrt_rx
    import usrt_pkg::*;
#(
    parameter int DATA_BITS = USRT_DATA_BITS,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 usrt_clk,
    input  logic                 RTS,
    input  logic                 RXD,
    output logic                 CTS,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 bit_stb;
    logic [1:0]           rts_sync_q;
    logic [1:0]           rxd_sync_q;
    logic                 rts_s;
    logic                 rxd_s;
    logic                 parity_bad;

    usrt_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_q, par_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 cts_q;

    usrt_sync_edge u_clk_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (usrt_clk),
        .rise_o (bit_stb)
    );

    // RTS and RXD share the depth of the usrt_clk synchronizer so data lines up with the strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rts_sync_q <= 2'b00;
            rxd_sync_q <= 2'b11;
        end else begin
            rts_sync_q <= {rts_sync_q[0], RTS};
            rxd_sync_q <= {rxd_sync_q[0], RXD};
        end
    end

    assign rts_s      = rts_sync_q[1];
    assign rxd_s      = rxd_sync_q[1];
    assign parity_bad = PARITY_EN && ((^shift_q) ^ par_q);

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        if (rx_ack) valid_d = 1'b0;

        if (state_q != ST_IDLE && !rts_s) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (bit_stb) begin
            case (state_q)
                ST_IDLE: begin
                    if (rts_s && rxd_s == USRT_START_BIT) begin
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    shift_d = DATA_BITS'({rxd_s, shift_q} >> 1);
                    if (cnt_q == CNT_W'(DATA_BITS - 1))
                        state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
                ST_PARITY: begin
                    par_d   = rxd_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    // A bad stop bit outranks a parity error; an ack in this clk frees the slot.
                    if (rxd_s != USRT_STOP_BIT) begin
                        ferr_d = 1'b1;
                    end else if (parity_bad) begin
                        perr_d = 1'b1;
                    end else if (valid_q && !rx_ack) begin
                        ovr_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses <= so every flop sees pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            cts_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            cts_q   <= (state_q == ST_IDLE) && !valid_q;
        end
    end

    assign CTS        = cts_q;
    assign rx_data    = data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;

endmodule
